// File: rtl/acc_exec_ctrl_pkg.sv
// Shared definitions for the accumulator execution controller:
// opcode values, FSM state encoding and a reserved-opcode helper.
package acc_exec_ctrl_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_NOT = 4'h8;
  localparam logic [3:0] OP_LDI = 4'h9;
  localparam logic [3:0] OP_SHL = 4'hA;
  localparam logic [3:0] OP_SHR = 4'hB;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    IMM   = 2'd2,
    HALT  = 2'd3
  } state_e;

  // C..E are reserved: executed as NOP but flagged.
  function automatic logic is_reserved(input logic [3:0] op);
    return (op >= 4'hC) && (op <= 4'hE);
  endfunction

endpackage

// File: rtl/acc_exec_ctrl_alu8.sv
// Combinational ALU for the accumulator controller.
// Ports:
//   a         in  accumulator value
//   b         in  register-file read data
//   op        in  opcode
//   result    out new accumulator value (valid when acc_we)
//   carry_out out new carry/borrow flag (valid when carry_we)
//   carry_we  out op updates cf (ADD/SUB/SHL/SHR)
//   acc_we    out op writes the accumulator
module alu8
  import acc_exec_ctrl_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   op,
  output logic [W-1:0] result,
  output logic         carry_out,
  output logic         carry_we,
  output logic         acc_we
);

  always_comb begin
    result    = a;
    carry_out = 1'b0;
    carry_we  = 1'b0;
    acc_we    = 1'b0;
    case (op)
      OP_LDA: begin result = b; acc_we = 1'b1; end
      OP_ADD: begin
        {carry_out, result} = {1'b0, a} + {1'b0, b};
        carry_we = 1'b1; acc_we = 1'b1;
      end
      OP_SUB: begin
        result    = a - b;
        carry_out = (a < b);
        carry_we  = 1'b1; acc_we = 1'b1;
      end
      OP_AND: begin result = a & b; acc_we = 1'b1; end
      OP_OR:  begin result = a | b; acc_we = 1'b1; end
      OP_XOR: begin result = a ^ b; acc_we = 1'b1; end
      OP_NOT: begin result = ~a;    acc_we = 1'b1; end
      OP_SHL: begin
        result    = {a[W-2:0], 1'b0};
        carry_out = a[W-1];
        carry_we  = 1'b1; acc_we = 1'b1;
      end
      OP_SHR: begin
        result    = {1'b0, a[W-1:1]};
        carry_out = a[0];
        carry_we  = 1'b1; acc_we = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/acc_exec_ctrl.sv
// Accumulator execution controller in front of a 16x8 register file.
// Takes instructions ([7:4] opcode, [3:0] Rn) over valid/ready, holds
// acc and flags, and drives the register file address/data/strobe.
// Ports:
//   clk, CLB               clock, async active-low clear
//   instr/instr_valid/instr_ready  fetch link (instruction or LDI immediate)
//   reg_rdata              combinational read data for reg_addr
//   reg_addr/reg_wdata/load_reg    register file write side
//   acc, zf, cf            accumulator and flags
//   illegal                sticky, reserved opcode executed
//   halted                 HLT executed
module acc_exec_ctrl
  import acc_exec_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4   // DATA_W must be ADDR_W+4
) (
  input  logic              clk,
  input  logic              CLB,
  input  logic [DATA_W-1:0] instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              load_reg,
  output logic [DATA_W-1:0] acc,
  output logic              zf,
  output logic              cf,
  output logic              illegal,
  output logic              halted
);

  state_e              r_state, w_next;
  logic [DATA_W-1:0]   r_ir, r_acc;
  logic                r_zf, r_cf, r_ill;
  logic [3:0]          w_op, w_in_op;
  logic                w_hs;
  logic [DATA_W-1:0]   w_res;
  logic                w_cout, w_carry_we, w_acc_we;

  assign w_op    = r_ir[DATA_W-1:ADDR_W];
  assign w_in_op = instr[DATA_W-1:ADDR_W];
  assign w_hs    = instr_valid && instr_ready;

  alu8 #(.W(DATA_W)) u_alu (
    .a         (r_acc),
    .b         (reg_rdata),
    .op        (w_op),
    .result    (w_res),
    .carry_out (w_cout),
    .carry_we  (w_carry_we),
    .acc_we    (w_acc_we)
  );

  // State register
  always_ff @(posedge clk or negedge CLB) begin
    if (!CLB) r_state <= FETCH;
    else      r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH: if (w_hs) w_next = (w_in_op == OP_LDI) ? IMM : EXEC;
      EXEC:  w_next = (w_op == OP_HLT) ? HALT : FETCH;
      IMM:   if (w_hs) w_next = FETCH;
      HALT:  w_next = HALT;
      default: w_next = FETCH;
    endcase
  end

  // Outputs; ready is gated by CLB so nothing is accepted during clear
  always_comb begin
    instr_ready = CLB && ((r_state == FETCH) || (r_state == IMM));
    load_reg    = (r_state == EXEC) && (w_op == OP_STA);
    halted      = (r_state == HALT);
    reg_addr    = r_ir[ADDR_W-1:0];
    reg_wdata   = r_acc;
    acc         = r_acc;
    zf          = r_zf;
    cf          = r_cf;
    illegal     = r_ill;
  end

  // IR, accumulator and flags
  always_ff @(posedge clk or negedge CLB) begin
    if (!CLB) begin
      r_ir  <= '0;
      r_acc <= '0;
      r_zf  <= 1'b0;
      r_cf  <= 1'b0;
      r_ill <= 1'b0;
    end else begin
      case (r_state)
        FETCH: if (w_hs) r_ir <= instr;
        IMM: if (w_hs) begin
          r_acc <= instr;
          r_zf  <= (instr == '0);
        end
        EXEC: begin
          if (w_acc_we) begin
            r_acc <= w_res;
            r_zf  <= (w_res == '0);
          end
          if (w_carry_we)       r_cf  <= w_cout;
          if (is_reserved(w_op)) r_ill <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
